// File: rtl/demux1x8_stream.sv
// demux1x8_stream: registered 1-to-8 stream demultiplexer.
// Each input word is steered to one of eight one-entry lane registers. The
// target lane is either the explicit in_sel or an internal round-robin pointer.
// Every lane has its own valid/ready handshake.

module demux1x8_stream #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             auto_mode,
    output logic [WIDTH-1:0] out_data [7:0],
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [2:0]       rr_ptr
);

    logic [2:0] tgt;
    logic [7:0] drain;
    logic       acc;

    // Target lane selection and input handshake. in_ready looks only at the
    // target lane, so a full round-robin lane stalls the input even when other
    // lanes are empty. Held low during reset.
    always_comb begin
        tgt      = auto_mode ? rr_ptr : in_sel;
        drain    = out_valid & out_ready;
        in_ready = rst_n & (~out_valid[tgt] | out_ready[tgt]);
        acc      = in_valid & in_ready;
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        // Lane holding register: refill has priority over drain, which gives
        // full throughput when a lane is drained and reloaded in one cycle.
        // Data is not cleared on drain, only the valid flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_data[g]  <= '0;
                out_valid[g] <= 1'b0;
            end else if (acc && (tgt == 3'(g))) begin
                out_data[g]  <= in_data;
                out_valid[g] <= 1'b1;
            end else if (drain[g]) begin
                out_valid[g] <= 1'b0;
            end
        end
    end

    // Round-robin pointer advances only on words accepted in auto mode and
    // keeps its value across mode changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 3'd0;
        end else if (acc && auto_mode) begin
            rr_ptr <= rr_ptr + 3'd1;
        end
    end

endmodule

// File: tb/tb_demux1x8_stream.sv
// Testbench for demux1x8_stream: per-lane scoreboard queues filled on accepted
// input words and emptied as lanes drain, plus directed scenario checks.

module tb_demux1x8_stream;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic [2:0]       in_sel;
    logic             in_valid;
    logic             in_ready;
    logic             auto_mode;
    logic [WIDTH-1:0] out_data [7:0];
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [2:0]       rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;
    int stall_cycles = 0;

    logic [WIDTH-1:0] sb_q [8][$];
    logic [2:0]       model_rr = 3'd0;

    demux1x8_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .auto_mode (auto_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reset discards all pending lane words in the model.
    always @(negedge rst_n) begin
        for (int i = 0; i < 8; i++) sb_q[i].delete();
        model_rr = 3'd0;
    end

    // Monitor at the falling edge: compare lane state against the scoreboard,
    // pop drained words, then push the word accepted at the coming rising edge.
    always @(negedge clk) begin
        logic [2:0] mt;
        logic       exp_rdy;
        if (!rst_n) begin
            check_eq("rst_out_valid", {24'd0, out_valid}, 32'd0);
            check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check_eq("rst_rr_ptr", {29'd0, rr_ptr}, 32'd0);
        end else begin
            mt = auto_mode ? model_rr : in_sel;
            exp_rdy = (sb_q[mt].size() == 0) || out_ready[mt];
            check_eq("mon_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            check_eq("mon_rr_ptr", {29'd0, rr_ptr}, {29'd0, model_rr});
            for (int i = 0; i < 8; i++) begin
                check_eq($sformatf("mon_valid%0d", i), {31'd0, out_valid[i]},
                         {31'd0, (sb_q[i].size() != 0)});
                if (out_valid[i] && out_ready[i]) begin
                    if (sb_q[i].size() == 0) begin
                        check_eq($sformatf("mon_unexp_drain%0d", i), 32'd1, 32'd0);
                    end else begin
                        check_eq($sformatf("mon_data%0d", i), {24'd0, out_data[i]},
                                 {24'd0, sb_q[i].pop_front()});
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb_q[mt].push_back(in_data);
                if (auto_mode) model_rr = model_rr + 3'd1;
            end
        end
    end

    // Present one word and hold it until accepted (bounded wait).
    task automatic send(input logic [WIDTH-1:0] d, input logic [2:0] s);
        int n;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            stall_cycles++;
            n++;
            if (n > 50) begin
                check_eq("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_sel    = 3'd0;
        in_valid  = 1'b0;
        auto_mode = 1'b0;
        out_ready = 8'h00;
        #3;
        check_eq("init_out_valid", {24'd0, out_valid}, 32'd0);
        check_eq("init_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("init_rr_ptr", {29'd0, rr_ptr}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("init_data%0d", i), {24'd0, out_data[i]}, 32'd0);

        // Explicit steering with all lanes blocked downstream.
        send(8'hA5, 3'd3);
        check_eq("expl_valid1", {24'd0, out_valid}, 32'h08);
        check_eq("expl_data3", {24'd0, out_data[3]}, 32'hA5);
        send(8'h3C, 3'd6);
        check_eq("expl_valid2", {24'd0, out_valid}, 32'h48);
        check_eq("expl_data6", {24'd0, out_data[6]}, 32'h3C);
        in_data  = 8'hC3;
        in_sel   = 3'd3;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("expl_stall", {31'd0, in_ready}, 32'd0);
        end
        check_eq("expl_no_overwrite", {24'd0, out_data[3]}, 32'hA5);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 8'hFF;
        idle(1);
        check_eq("expl_drained", {24'd0, out_valid}, 32'h00);
        check_eq("expl_data_kept", {24'd0, out_data[3]}, 32'hA5);

        // Round-robin, all lanes ready: no stalls, ten words over lanes 0..7,0,1.
        auto_mode    = 1'b1;
        stall_cycles = 0;
        for (int k = 0; k < 10; k++) send(8'h10 + 8'(k), 3'd0);
        check_eq("rr_no_stall", stall_cycles, 0);
        check_eq("rr_ptr_end", {29'd0, rr_ptr}, 32'd2);
        check_eq("rr_last_lane1", {24'd0, out_data[1]}, 32'h19);
        check_eq("rr_lane0", {24'd0, out_data[0]}, 32'h18);
        idle(2);

        // Round-robin stall: lane 5 full and blocked, pointer at 5.
        out_ready = 8'hDF;
        auto_mode = 1'b0;
        send(8'hA0, 3'd5);
        auto_mode = 1'b1;
        for (int k = 0; k < 3; k++) send(8'h20 + 8'(k), 3'd0);
        check_eq("rrs_ptr5", {29'd0, rr_ptr}, 32'd5);
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("rrs_stall", {31'd0, in_ready}, 32'd0);
            check_eq("rrs_hold", {29'd0, rr_ptr}, 32'd5);
        end
        @(posedge clk);
        #1;
        out_ready = 8'hFF;
        @(negedge clk);
        check_eq("rrs_release", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("rrs_ptr6", {29'd0, rr_ptr}, 32'd6);
        check_eq("rrs_data5", {24'd0, out_data[5]}, 32'h55);
        check_eq("rrs_valid5", {31'd0, out_valid[5]}, 32'd1);
        idle(2);

        // Same-lane drain and refill at full rate.
        auto_mode = 1'b0;
        in_sel    = 3'd2;
        in_data   = 8'h01;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("same_ready", {31'd0, in_ready}, 32'd1);
            if (k > 0) begin
                check_eq("same_valid", {31'd0, out_valid[2]}, 32'd1);
                check_eq("same_data", {24'd0, out_data[2]}, k);
            end
            @(posedge clk);
            #1;
            in_data = 8'(k + 2);
        end
        in_valid = 1'b0;
        check_eq("same_valid_last", {31'd0, out_valid[2]}, 32'd1);
        check_eq("same_data_last", {24'd0, out_data[2]}, 32'h03);
        idle(2);

        // Fill all lanes, then assert reset mid-cycle.
        out_ready = 8'h00;
        for (int k = 0; k < 8; k++) send(8'h80 + 8'(k), 3'(k));
        check_eq("fill_valid", {24'd0, out_valid}, 32'hFF);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", {24'd0, out_valid}, 32'h00);
        check_eq("mid_rst_rr", {29'd0, rr_ptr}, 32'd0);
        check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        idle(1);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("post_rst_data%0d", i), {24'd0, out_data[i]}, 32'd0);

        // Mode switch keeps the round-robin pointer.
        out_ready = 8'hFF;
        auto_mode = 1'b1;
        for (int k = 0; k < 3; k++) send(8'h30 + 8'(k), 3'd0);
        check_eq("ms_rr3", {29'd0, rr_ptr}, 32'd3);
        auto_mode = 1'b0;
        send(8'h40, 3'd7);
        send(8'h41, 3'd7);
        check_eq("ms_rr_hold", {29'd0, rr_ptr}, 32'd3);
        check_eq("ms_data7", {24'd0, out_data[7]}, 32'h41);
        auto_mode = 1'b1;
        send(8'h77, 3'd0);
        check_eq("ms_data3", {24'd0, out_data[3]}, 32'h77);
        check_eq("ms_rr4", {29'd0, rr_ptr}, 32'd4);
        idle(3);

        begin
            int left;
            left = 0;
            for (int i = 0; i < 8; i++) left += sb_q[i].size();
            check_eq("sb_empty", left, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux1x8_stream.md
Name: demux1x8_stream

Overview:
- Registered 1-to-8 demultiplexer: the distribution end of the 8-lane select datapath that funnels 8 lanes into one.
- Takes one WIDTH-bit input stream with a valid/ready handshake and steers each word into one of 8 output lanes.
- Each output lane has a one-entry holding register and its own valid/ready handshake.
- The target lane comes either from an explicit select or from an internal round-robin pointer.

Parameters:
- WIDTH, 8, data width of the input stream and of each output lane.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  input word.
- in_sel  input  3  explicit target lane; used only when auto_mode=0.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts the input word this cycle.
- auto_mode  input  1  1: target lane = rr_ptr; 0: target lane = in_sel.
- out_data  output  WIDTH x 8  unpacked array [7:0] of per-lane holding registers.
- out_valid  output  8  per-lane valid.
- out_ready  input  8  per-lane downstream ready.
- rr_ptr  output  3  current round-robin pointer.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - all out_data lanes = 0, out_valid = 8'h00, rr_ptr = 0.
  - in_ready = 0, forced low independent of other inputs.
  - State updates resume on the first rising clk edge after deassertion.
- Target lane: tgt = auto_mode ? rr_ptr : in_sel. Combinational, evaluated every cycle.
- Lane drain: drain[i] = out_valid[i] & out_ready[i].
- in_ready (combinational) = !out_valid[tgt] | out_ready[tgt]. Depends only on the target lane, never on other lanes.
- Accept: acc = in_valid & in_ready. On the clock edge:
  - out_data[tgt] <= in_data, out_valid[tgt] <= 1.
  - Latency: word visible on the lane exactly 1 cycle after acceptance.
- Drain without refill: out_valid[i] <= 0. out_data[i] holds its last value and is not cleared.
- Simultaneous drain and refill of the same lane: the new word replaces the old one and out_valid stays 1. This gives full throughput on a single lane.
- Lanes other than tgt: only drain logic applies, all in parallel. Any number of lanes may drain in the same cycle.
- rr_ptr:
  - increments by 1 on each accepted word while auto_mode=1; wraps 7 -> 0.
  - holds when no accept occurs or when auto_mode=0.
  - No skipping: if lane rr_ptr is full and not draining, in_ready=0 and the input stalls even if other lanes are empty.
- auto_mode may change on any cycle. It takes effect the same cycle (combinational tgt) and rr_ptr keeps its value across mode changes.
- in_valid=0: no state change except drains. in_sel and in_data are don't-care.
- Handshake protocol on both sides:
  - Once out_valid[i]=1, out_data[i] is stable until drained.
  - The upstream must hold in_data/in_sel stable while in_valid=1 and in_ready=0. The block does not check this.
- Reset asserted mid-transfer: all pending lane words are discarded, out_valid clears immediately (asynchronous), and rr_ptr returns to 0.

Test Plan:
- Reset: assert rst_n=0 mid-run with out_valid=8'hFF -> out_valid=8'h00, rr_ptr=0, in_ready=0 immediately, no clock needed. After release, all out_data lanes = 0.
- Explicit steering: auto_mode=0, out_ready=0, send 8'hA5 sel=3 then 8'h3C sel=6.
  - Next cycles: out_valid=8'h08, then 8'h48; out_data[3]=A5, out_data[6]=3C.
  - Third word to sel=3 -> in_ready=0 (stall).
- Round-robin: auto_mode=1, out_ready=8'hFF, send 10 words 8'h10..8'h19 back-to-back -> lanes 0..7 then 0,1 receive them in order, rr_ptr ends at 2, in_ready stays 1 throughout.
- Round-robin stall: auto_mode=1, rr_ptr=5, lane 5 full with out_ready[5]=0, all other lanes empty -> in_ready=0 and rr_ptr holds at 5. Raising out_ready[5] accepts the word to lane 5 in the same cycle and rr_ptr becomes 6.
- Same-lane drain+refill: auto_mode=0, sel=2, out_ready[2]=1, stream 8'h01,8'h02,8'h03 -> out_valid[2] stays 1 for 3 consecutive cycles, out_data[2]=01,02,03 on successive cycles, in_ready constantly 1.
- Mode switch: auto_mode=1 and accept 3 words (rr_ptr=3); switch to auto_mode=0 and send 2 words to sel=7; switch back -> rr_ptr still 3 and the next word lands on lane 3.
